// File: rtl/timer_access.sv
// timer_access: atomic 64-bit access to mtime/mtimecmp over a 32-bit timer port.
// Reads use hi/lo/hi sampling with bounded retry; writes park the low word
// (all-ones for mtimecmp, zero for mtime) before writing hi and then lo.
//
// state  | meaning
// IDLE   | waiting for a request, req_ready high
// RD_HI1 | sample high word of the selected register into hi1
// RD_LO  | sample low word
// RD_HI2 | resample high word; equal -> done, differ -> retry or error
// WR_LO1 | park low word so no spurious compare hit while hi changes
// WR_HI  | write high word
// WR_LO2 | write final low word
// RESP   | hold response until rsp_ready
module timer_access #(
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err,
  output logic [1:0]  io_addr_3_2,
  output logic        io_we,
  output logic [31:0] io_din,
  input  logic [31:0] io_dout
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, RD_HI1, RD_LO, RD_HI2, WR_LO1, WR_HI, WR_LO2, RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q;
  logic [63:0]   wdata_q;
  logic [31:0]   hi1_q;
  logic [31:0]   lo_q;
  logic [RW-1:0] retry_q;
  logic [63:0]   rsp_data_q;
  logic          rsp_err_q;

  logic       hi_match;
  logic       retry_done;
  logic [1:0] base;

  assign hi_match   = (io_dout == hi1_q);
  assign retry_done = (retry_q == MAX_R);
  // ops 01 and 10 address mtimecmp, ops 00 and 11 address mtime
  assign base       = {op_q[1] ^ op_q[0], 1'b0};

  // state register
  always_ff @(posedge clk) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_op[1] ? WR_LO1 : RD_HI1;
      RD_HI1:  state_d = RD_LO;
      RD_LO:   state_d = RD_HI2;
      RD_HI2:  state_d = (hi_match || retry_done) ? RESP : RD_LO;
      WR_LO1:  state_d = WR_HI;
      WR_HI:   state_d = WR_LO2;
      WR_LO2:  state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // timer port drive, decoded from state and captured op
  always_comb begin
    io_we       = 1'b0;
    io_addr_3_2 = 2'b00;
    io_din      = 32'h0;
    case (state_q)
      RD_HI1, RD_HI2: io_addr_3_2 = base | 2'b01;
      RD_LO:          io_addr_3_2 = base;
      WR_LO1: begin
        io_we       = 1'b1;
        io_addr_3_2 = base;
        io_din      = op_q[0] ? 32'h0000_0000 : 32'hFFFF_FFFF;
      end
      WR_HI: begin
        io_we       = 1'b1;
        io_addr_3_2 = base | 2'b01;
        io_din      = wdata_q[63:32];
      end
      WR_LO2: begin
        io_we       = 1'b1;
        io_addr_3_2 = base;
        io_din      = wdata_q[31:0];
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

  // request capture, read sampling, retry count and response registers
  always_ff @(posedge clk) begin
    if (!resetb) begin
      op_q       <= 2'b00;
      wdata_q    <= 64'h0;
      hi1_q      <= 32'h0;
      lo_q       <= 32'h0;
      retry_q    <= '0;
      rsp_data_q <= 64'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          op_q    <= req_op;
          wdata_q <= req_data;
          retry_q <= '0;
        end
        RD_HI1: hi1_q <= io_dout;
        RD_LO:  lo_q  <= io_dout;
        RD_HI2: begin
          if (hi_match) begin
            rsp_data_q <= {hi1_q, lo_q};
            rsp_err_q  <= 1'b0;
          end else if (retry_done) begin
            rsp_data_q <= {io_dout, lo_q};
            rsp_err_q  <= 1'b1;
          end else begin
            hi1_q   <= io_dout;
            retry_q <= retry_q + RW'(1);
          end
        end
        WR_LO2: begin
          rsp_data_q <= wdata_q;
          rsp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_access.sv
// Bench for timer_access: running timer model, protocol-level read/write
// reference, directed corner cases followed by randomized transactions.
module tb_timer_access;
  localparam int MAXR = 3;

  logic        clk = 1'b0;
  logic        resetb;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [63:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  io_addr_3_2;
  logic        io_we;
  logic [31:0] io_din;
  logic [31:0] io_dout;

  int checks = 0;
  int errors = 0;

  logic [63:0] mtime = 64'h0;
  logic [63:0] mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF;
  logic        load_req;
  logic [63:0] load_val;
  logic        hostile;
  logic [33:0] wq[$];

  logic [63:0] last_d;
  logic        last_e;
  int          last_lat;

  always #5 clk = ~clk;

  timer_access #(.MAX_RETRY(MAXR)) dut (
    .clk(clk), .resetb(resetb),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .io_addr_3_2(io_addr_3_2), .io_we(io_we), .io_din(io_din), .io_dout(io_dout)
  );

  // hostile mode makes the mtime high word differ on every sample
  function automatic logic [31:0] hi_of(input logic [63:0] x, input logic hos);
    return hos ? (x[63:32] ^ x[31:0]) : x[63:32];
  endfunction

  always_comb begin
    case (io_addr_3_2)
      2'b00:   io_dout = mtime[31:0];
      2'b01:   io_dout = hi_of(mtime, hostile);
      2'b10:   io_dout = mtimecmp[31:0];
      default: io_dout = mtimecmp[63:32];
    endcase
  end

  // timer: free-running mtime, word writes take priority over counting
  always @(posedge clk) begin
    if (load_req) mtime <= load_val;
    else if (io_we && !io_addr_3_2[1]) begin
      if (io_addr_3_2[0]) mtime[63:32] <= io_din;
      else                mtime[31:0]  <= io_din;
    end else mtime <= mtime + 64'd1;
    if (io_we && io_addr_3_2[1]) begin
      if (io_addr_3_2[0]) mtimecmp[63:32] <= io_din;
      else                mtimecmp[31:0]  <= io_din;
    end
  end

  always @(negedge clk) if (io_we === 1'b1) wq.push_back({io_addr_3_2, io_din});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // value seen at cycle c after acceptance is v + c - 1 (load lands on the accept edge)
  task automatic predict_mtime(input logic [63:0] v, input logic hos,
                               output logic [63:0] d, output logic e, output int lat);
    logic [31:0] h1, h2;
    logic [63:0] t;
    logic [31:0] l;
    d = 64'h0; e = 1'b0; lat = 0;
    h1 = hi_of(v, hos);
    for (int r = 0; r <= MAXR; r++) begin
      t = v + 64'(1 + 2 * r);
      l = t[31:0];
      h2 = hi_of(v + 64'(2 + 2 * r), hos);
      lat = 4 + 2 * r;
      if (h2 == h1) begin d = {h1, l}; e = 1'b0; return; end
      if (r == MAXR) begin d = {h2, l}; e = 1'b1; return; end
      h1 = h2;
    end
  endtask

  task automatic txn(input logic [1:0] op, input logic [63:0] d, input logic [63:0] v,
                     input logic hos, input int hold);
    logic [63:0] exp_d, got_d;
    logic        exp_e;
    int          exp_lat, lat;
    logic [1:0]  b;
    logic [33:0] exp_w[3];
    case (op)
      2'b00:   predict_mtime(v, hos, exp_d, exp_e, exp_lat);
      2'b01:   begin exp_d = mtimecmp; exp_e = 1'b0; exp_lat = 4; end
      default: begin exp_d = d; exp_e = 1'b0; exp_lat = 4; end
    endcase
    @(negedge clk);
    chk("ready_idle", 64'(req_ready), 64'd1);
    hostile = hos;
    req_valid = 1'b1; req_op = op; req_data = d;
    load_req = (op == 2'b00); load_val = v;
    wq.delete();
    @(posedge clk); #1;
    req_valid = 1'b0; load_req = 1'b0; req_data = {$urandom, $urandom};
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_err", 64'(rsp_err), 64'(exp_e));
    chk("resp_io", {29'h0, io_we, io_addr_3_2, io_din}, 64'h0);
    chk("resp_ready", 64'(req_ready), 64'd0);
    if (op == 2'b11) chk("mtime_written", mtime, d);
    got_d = rsp_data; last_d = rsp_data; last_e = rsp_err; last_lat = lat;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_data", rsp_data, got_d);
      chk("hold_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    chk("idle_after", 64'(req_ready), 64'd1);
    chk("rsp_dropped", 64'(rsp_valid), 64'd0);
    if (op[1]) begin
      b = (op == 2'b10) ? 2'b10 : 2'b00;
      exp_w[0] = {b, (op == 2'b10) ? 32'hFFFF_FFFF : 32'h0};
      exp_w[1] = {b | 2'b01, d[63:32]};
      exp_w[2] = {b, d[31:0]};
      chk("we_count", 64'(wq.size()), 64'd3);
      if (wq.size() == 3)
        for (int i = 0; i < 3; i++) chk("we_pulse", 64'(wq[i]), 64'(exp_w[i]));
      if (op == 2'b10) chk("mtimecmp_written", mtimecmp, d);
    end else chk("read_no_we", 64'(wq.size()), 64'd0);
    hostile = 1'b0;
  endtask

  initial begin
    logic [1:0]  op;
    logic [63:0] d, v;
    logic        hos;
    resetb = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_data = 64'h0; rsp_ready = 1'b0;
    load_req = 1'b1; load_val = 64'h0; hostile = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_err", 64'(rsp_err), 64'd0);
    chk("rst_data", rsp_data, 64'h0);
    chk("rst_io", {29'h0, io_we, io_addr_3_2, io_din}, 64'h0);
    resetb = 1'b1; load_req = 1'b0;

    txn(2'b00, 64'h0, 64'h0000_0005_0000_1000, 1'b0, 0);
    chk("read_plain", last_d, 64'h0000_0005_0000_1001);
    txn(2'b00, 64'h0, 64'h0000_0002_FFFF_FFFE, 1'b0, 0);
    chk("read_carry", last_d, 64'h0000_0003_0000_0001);
    chk("read_carry_lat", 64'(last_lat), 64'd6);
    txn(2'b00, 64'h0, 64'h0000_0007_0000_0100, 1'b1, 0);
    chk("hostile_err", 64'(last_e), 64'd1);
    chk("hostile_lat", 64'(last_lat), 64'd10);
    txn(2'b00, 64'h0, 64'h0000_0007_0000_0200, 1'b1, 2);
    chk("retry_cleared_lat", 64'(last_lat), 64'd10);
    txn(2'b10, 64'h0000_0001_2345_6789, 64'h0, 1'b0, 0);
    txn(2'b01, 64'h0, 64'h0, 1'b0, 5);
    chk("cmp_readback", last_d, 64'h0000_0001_2345_6789);
    txn(2'b11, 64'h1357_9BDF_0246_8ACE, 64'h0, 1'b0, 3);

    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_data = 64'hDEAD_BEEF_CAFE_F00D; wq.delete();
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("wr_hi_drive", {31'h0, io_we, io_addr_3_2, io_din}, {31'h0, 1'b1, 2'b01, 32'hDEAD_BEEF});
    resetb = 1'b0;
    @(posedge clk); #1;
    chk("midrst_ready", 64'(req_ready), 64'd1);
    chk("midrst_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_data", rsp_data, 64'h0);
    chk("midrst_io", {29'h0, io_we, io_addr_3_2, io_din}, 64'h0);
    resetb = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_pulses", 64'(wq.size()), 64'd2);
    chk("midrst_idle", 64'(req_ready), 64'd1);

    repeat (24) begin
      op = 2'($urandom_range(0, 3));
      d = {$urandom, $urandom};
      v = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) v[31:0] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      hos = (op == 2'b00) && ($urandom_range(0, 3) == 0);
      txn(op, d, v, hos, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_access.md
TIMER_ACCESS -- requirements
Module: timer_access

Interface
REQ-001 Parameter: MAX_RETRY, default 3, maximum hi/lo/hi re-read attempts before error response.
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 resetb  input  1  reset is synchronous and active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block idle and able to accept.
REQ-006 req_op  input  2  00 read mtime, 01 read mtimecmp, 10 write mtimecmp, 11 write mtime.
REQ-007 req_data  input  64  write value; ignored for reads.
REQ-008 rsp_valid  output  1  response held until rsp_ready.
REQ-009 rsp_ready  input  1  consumer accepts response.
REQ-010 rsp_data  output  64  read result; write echoes req_data.
REQ-011 rsp_err  output  1  read retry limit exceeded; rsp_data then holds last sample.
REQ-012 io_addr_3_2  output  2  timer word select: 00 mtime lo, 01 mtime hi, 10 mtimecmp lo, 11 mtimecmp hi.
REQ-013 io_we  output  1  write strobe, one cycle per word.
REQ-014 io_din  output  32  write data to timer.
REQ-015 io_dout  input  32  timer read data, combinational from io_addr_3_2, sampled at posedge.

Function
REQ-016 States SHALL be IDLE, RD_HI1, RD_LO, RD_HI2, WR_LO1, WR_HI, WR_LO2, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; request accepted on req_valid && req_ready; req_op/req_data captured at acceptance.
REQ-018 IDLE and RESP SHALL drive io_we=0, io_addr_3_2=00, io_din=0.
REQ-019 Reads: base = 00 (op 00) or 10 (op 01); RD_HI1 drives base|01 and latches hi1; RD_LO drives base and latches lo; RD_HI2 drives base|01 and compares against hi1.
REQ-020 RD_HI2 match SHALL go to RESP with rsp_data={hi1,lo}, rsp_err=0.
REQ-021 RD_HI2 mismatch SHALL set hi1<=sampled hi, increment retry count, return to RD_LO; at count==MAX_RETRY go to RESP with rsp_err=1, rsp_data={sampled hi,lo}.
REQ-022 Retry count SHALL clear at each accepted request; width ceil(log2(MAX_RETRY+1)).
REQ-023 Write mtimecmp: WR_LO1 writes 0xFFFFFFFF to 10, WR_HI writes req_data[63:32] to 11, WR_LO2 writes req_data[31:0] to 10, io_we=1 each state.
REQ-024 Write mtime: WR_LO1 writes 0x00000000 to 00, WR_HI writes req_data[63:32] to 01, WR_LO2 writes req_data[31:0] to 00.
REQ-025 Latency: read without retry rsp_valid 4 cycles after acceptance edge; each retry adds 2; write rsp_valid 4 cycles after acceptance.
REQ-026 RESP SHALL hold rsp_valid, rsp_data, rsp_err stable until rsp_ready; on rsp_valid && rsp_ready go IDLE next cycle.
REQ-027 A new request SHALL NOT be accepted in the cycle the response is consumed (req_ready=0 in RESP).
REQ-028 rsp_err SHALL be 0 for all writes.

Reset
REQ-029 resetb=0 at posedge SHALL force IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, io_we=0, io_addr_3_2=00, io_din=0, retry count 0, from any state including mid-sequence.
REQ-030 Reset mid-write SHALL leave no further io_we pulses; partially written timer state is not repaired.

Verification
REQ-031 Timer model mtime=0x0000_0005_0000_1000 running, op 00, rsp_ready=1 -> rsp_valid 4 cycles later, rsp_data hi=0x5, lo=0x1000+1 (sampled in RD_LO), rsp_err=0.
REQ-032 mtime=0x0000_0002_FFFF_FFFE, op 00 -> one retry, rsp_data=0x0000_0003_xxxx (lo small), latency 6, rsp_err=0.
REQ-033 Model forcing hi to change every read, MAX_RETRY=3 -> rsp_err=1 after 3 retries, latency 10.
REQ-034 op 10, req_data=0x0000_0001_2345_6789 -> io_we pulses at 10/0xFFFFFFFF, 11/0x1, 10/0x23456789; mtimecmp=0x1_2345_6789; no irq before match.
REQ-035 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0; req_valid ignored until IDLE.
REQ-036 resetb=0 during WR_HI -> next cycle IDLE, io_we=0, rsp_valid=0, no WR_LO2 write.
